// File: rtl/uart_loader_pkg.sv
// Shared constants and state type for the UART program loader.
// Command bytes, default reply bytes and the frame FSM states.
package uart_loader_pkg;

    localparam logic [7:0] CMD_WRITE_INSN = 8'h01;
    localparam logic [7:0] CMD_WRITE_DATA = 8'h02;
    localparam logic [7:0] CMD_RUN        = 8'h03;
    localparam logic [7:0] CMD_HALT       = 8'h04;

    localparam logic [7:0] DEF_ACK_BYTE = 8'hA5;
    localparam logic [7:0] DEF_NAK_BYTE = 8'h5A;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        LEN,
        PAYLOAD
    } loader_state_t;

endpackage

// File: rtl/uart_program_loader_if.sv
// Loader bus: UART receive side, memory write ports, run line and reply.
// master is the loader, slave is the surrounding system.
interface uart_program_loader_if;

    logic        rx_rd;
    logic [7:0]  rx_data;
    logic [31:0] insn_addr;
    logic [31:0] insn_din;
    logic        insn_we;
    logic [31:0] data_addr;
    logic [31:0] data_din;
    logic        data_we;
    logic        run;
    logic        busy;
    logic        ack_valid;
    logic [7:0]  ack_data;
    logic [15:0] err_count;

    modport master (
        input  rx_rd, rx_data,
        output insn_addr, insn_din, insn_we,
        output data_addr, data_din, data_we,
        output run, busy, ack_valid, ack_data, err_count
    );

    modport slave (
        output rx_rd, rx_data,
        input  insn_addr, insn_din, insn_we,
        input  data_addr, data_din, data_we,
        input  run, busy, ack_valid, ack_data, err_count
    );

endinterface

// File: rtl/loader_idle_timer.sv
// Inactivity timer: pulses expired after TIMEOUT_CYCLES enabled cycles
// with no clear; a clear in the firing cycle wins.
module loader_idle_timer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    logic [31:0] r_cnt;

    assign expired = enable & ~clear &
                     (r_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (reset || !enable || clear || expired)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 32'd1;
    end

endmodule

// File: rtl/uart_program_loader.sv
// Framed UART loader: parses commands, assembles LE words and issues
// instruction/data write strobes, run control and ACK/NAK replies.
module uart_program_loader
    import uart_loader_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd5_000_000,
    parameter logic [7:0]  ACK_BYTE       = DEF_ACK_BYTE,
    parameter logic [7:0]  NAK_BYTE       = DEF_NAK_BYTE
) (
    input logic                  clk,
    input logic                  reset,
    uart_program_loader_if.master bus
);

    loader_state_t r_state, w_state_n;

    logic        r_rx_rd_d;
    logic [1:0]  r_idx;
    logic [23:0] r_shift;
    logic [31:0] r_addr;
    logic [31:0] r_remain;
    logic        r_sel_data;
    logic        r_run;
    logic [31:0] r_insn_addr, r_insn_din;
    logic [31:0] r_data_addr, r_data_din;
    logic        r_insn_we, r_data_we;
    logic        r_ack_valid;
    logic [7:0]  r_ack_data;
    logic [15:0] r_err;

    logic        w_evt, w_last, w_busy, w_is_wr, w_expired;
    logic [31:0] w_word;
    logic        w_ack, w_nak, w_wr, w_ld_addr, w_ld_len;
    logic        w_run_set, w_run_clr;

    assign w_evt   = bus.rx_rd & ~r_rx_rd_d;
    assign w_last  = (r_idx == 2'd3);
    assign w_busy  = (r_state != IDLE);
    assign w_word  = {bus.rx_data, r_shift};
    assign w_is_wr = (bus.rx_data == CMD_WRITE_INSN) ||
                     (bus.rx_data == CMD_WRITE_DATA);

    loader_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (w_busy),
        .clear  (w_evt),
        .expired(w_expired)
    );

    always_comb begin
        w_state_n = r_state;
        w_ack     = 1'b0;
        w_nak     = 1'b0;
        w_wr      = 1'b0;
        w_ld_addr = 1'b0;
        w_ld_len  = 1'b0;
        w_run_set = 1'b0;
        w_run_clr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_evt) begin
                    unique case (1'b1)
                        w_is_wr: begin
                            w_state_n = ADDR;
                            w_run_clr = 1'b1;
                        end
                        (bus.rx_data == CMD_RUN): begin
                            w_run_set = 1'b1;
                            w_ack     = 1'b1;
                        end
                        (bus.rx_data == CMD_HALT): begin
                            w_run_clr = 1'b1;
                            w_ack     = 1'b1;
                        end
                        default: w_nak = 1'b1;
                    endcase
                end
            end
            ADDR: begin
                if (w_evt && w_last) begin
                    w_state_n = LEN;
                    w_ld_addr = 1'b1;
                end
            end
            LEN: begin
                if (w_evt && w_last) begin
                    w_ld_len = 1'b1;
                    if (w_word == 32'd0) begin
                        w_state_n = IDLE;
                        w_ack     = 1'b1;
                    end else begin
                        w_state_n = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_evt && w_last) begin
                    w_wr = 1'b1;
                    if (r_remain == 32'd1) begin
                        w_state_n = IDLE;
                        w_ack     = 1'b1;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        // The timer never fires in IDLE or on a byte event.
        if (w_expired) begin
            w_state_n = IDLE;
            w_nak     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rx_rd_d   <= 1'b0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_sel_data  <= 1'b0;
            r_run       <= 1'b0;
            r_insn_addr <= '0;
            r_insn_din  <= '0;
            r_insn_we   <= 1'b0;
            r_data_addr <= '0;
            r_data_din  <= '0;
            r_data_we   <= 1'b0;
            r_ack_valid <= 1'b0;
            r_ack_data  <= '0;
            r_err       <= '0;
        end else begin
            r_rx_rd_d   <= bus.rx_rd;
            r_state     <= w_state_n;
            r_insn_we   <= 1'b0;
            r_data_we   <= 1'b0;
            r_ack_valid <= 1'b0;
            if (w_state_n != r_state)
                r_idx <= '0;
            else if (w_evt)
                r_idx <= r_idx + 2'd1;
            if (w_evt)
                r_shift <= w_word[31:8];
            if (w_evt && !w_busy)
                r_sel_data <= (bus.rx_data == CMD_WRITE_DATA);
            if (w_ld_addr)
                r_addr <= w_word;
            if (w_ld_len)
                r_remain <= w_word;
            if (w_wr) begin
                if (r_sel_data) begin
                    r_data_we   <= 1'b1;
                    r_data_addr <= r_addr;
                    r_data_din  <= w_word;
                end else begin
                    r_insn_we   <= 1'b1;
                    r_insn_addr <= r_addr;
                    r_insn_din  <= w_word;
                end
                r_addr   <= r_addr + 32'd4;
                r_remain <= r_remain - 32'd1;
            end
            if (w_run_set)
                r_run <= 1'b1;
            else if (w_run_clr)
                r_run <= 1'b0;
            if (w_ack) begin
                r_ack_valid <= 1'b1;
                r_ack_data  <= ACK_BYTE;
            end else if (w_nak) begin
                r_ack_valid <= 1'b1;
                r_ack_data  <= NAK_BYTE;
                if (r_err != 16'hFFFF)
                    r_err <= r_err + 16'd1;
            end
        end
    end

    assign bus.insn_addr = r_insn_addr;
    assign bus.insn_din  = r_insn_din;
    assign bus.insn_we   = r_insn_we;
    assign bus.data_addr = r_data_addr;
    assign bus.data_din  = r_data_din;
    assign bus.data_we   = r_data_we;
    assign bus.run       = r_run;
    assign bus.busy      = w_busy;
    assign bus.ack_valid = r_ack_valid;
    assign bus.ack_data  = r_ack_data;
    assign bus.err_count = r_err;

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: command table, directed frames and
// random frames checked against a frame-level expectation model.
module tb_uart_program_loader;
    import uart_loader_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_program_loader_if bus();

    uart_program_loader #(
        .TIMEOUT_CYCLES(32'd100),
        .ACK_BYTE      (8'hA5),
        .NAK_BYTE      (8'h5A)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_err = 0;

    logic [63:0] q_insn[$], q_data[$], e_insn[$], e_data[$];
    logic [7:0]  q_ack[$], e_ack[$];
    logic [31:0] pl[$];
    logic [15:0] exp_err = '0;
    logic        exp_run = 1'b0;
    logic        ack_we_same = 1'b0;

    typedef struct {
        logic [7:0]  b;
        logic        run;
        logic [7:0]  ack;
        logic [15:0] err;
    } vec_t;

    vec_t tbl[7];

    always @(negedge clk) begin
        if (bus.insn_we) q_insn.push_back({bus.insn_addr, bus.insn_din});
        if (bus.data_we) q_data.push_back({bus.data_addr, bus.data_din});
        if (bus.ack_valid) begin
            q_ack.push_back(bus.ack_data);
            ack_we_same = bus.insn_we | bus.data_we;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx_rd = 1'b1;
        bus.rx_data = b;
        @(negedge clk);
        bus.rx_rd = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
    endtask

    // Sends a full write frame with payload pl and records what the
    // loader must produce for it.
    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                              input int gap);
        send_byte(cmd, gap);
        chk("run cleared by write cmd", 64'(bus.run), 64'(0));
        send_word(addr, gap);
        send_word(32'(pl.size()), gap);
        foreach (pl[i]) send_word(pl[i], gap);
        for (int i = 0; i < pl.size(); i++) begin
            if (cmd == CMD_WRITE_DATA)
                e_data.push_back({addr + 32'(4 * i), pl[i]});
            else
                e_insn.push_back({addr + 32'(4 * i), pl[i]});
        end
        e_ack.push_back(8'hA5);
        exp_run = 1'b0;
    endtask

    task automatic check_q(input string nm);
        repeat (3) @(negedge clk);
        chk({nm, " insn count"}, 64'(q_insn.size()), 64'(e_insn.size()));
        for (int i = 0; i < q_insn.size() && i < e_insn.size(); i++)
            chk({nm, " insn write"}, q_insn[i], e_insn[i]);
        chk({nm, " data count"}, 64'(q_data.size()), 64'(e_data.size()));
        for (int i = 0; i < q_data.size() && i < e_data.size(); i++)
            chk({nm, " data write"}, q_data[i], e_data[i]);
        chk({nm, " ack count"}, 64'(q_ack.size()), 64'(e_ack.size()));
        for (int i = 0; i < q_ack.size() && i < e_ack.size(); i++)
            chk({nm, " ack byte"}, 64'(q_ack[i]), 64'(e_ack[i]));
        chk({nm, " err_count"}, 64'(bus.err_count), 64'(exp_err));
        chk({nm, " run"}, 64'(bus.run), 64'(exp_run));
        chk({nm, " busy"}, 64'(bus.busy), 64'(0));
        q_insn.delete(); q_data.delete(); q_ack.delete();
        e_insn.delete(); e_data.delete(); e_ack.delete();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " insn_addr"}, 64'(bus.insn_addr), 64'(0));
        chk({nm, " insn_din"}, 64'(bus.insn_din), 64'(0));
        chk({nm, " insn_we"}, 64'(bus.insn_we), 64'(0));
        chk({nm, " data_addr"}, 64'(bus.data_addr), 64'(0));
        chk({nm, " data_din"}, 64'(bus.data_din), 64'(0));
        chk({nm, " data_we"}, 64'(bus.data_we), 64'(0));
        chk({nm, " run"}, 64'(bus.run), 64'(0));
        chk({nm, " busy"}, 64'(bus.busy), 64'(0));
        chk({nm, " ack_valid"}, 64'(bus.ack_valid), 64'(0));
        chk({nm, " ack_data"}, 64'(bus.ack_data), 64'(0));
        chk({nm, " err_count"}, 64'(bus.err_count), 64'(0));
    endtask

    initial begin
        logic [7:0] c;
        int r;
        tbl[0] = '{8'h03, 1'b1, 8'hA5, 16'd0};
        tbl[1] = '{8'h04, 1'b0, 8'hA5, 16'd0};
        tbl[2] = '{8'h7E, 1'b0, 8'h5A, 16'd1};
        tbl[3] = '{8'h03, 1'b1, 8'hA5, 16'd1};
        tbl[4] = '{8'hFF, 1'b1, 8'h5A, 16'd2};
        tbl[5] = '{8'h00, 1'b1, 8'h5A, 16'd3};
        tbl[6] = '{8'h04, 1'b0, 8'hA5, 16'd3};

        bus.rx_rd = 1'b0;
        bus.rx_data = 8'h00;
        repeat (4) @(negedge clk);
        chk_zero("reset");
        reset = 1'b0;

        // single-byte commands
        foreach (tbl[i]) begin
            send_byte(tbl[i].b, 2);
            chk("tbl run", 64'(bus.run), 64'(tbl[i].run));
            chk("tbl ack count", 64'(q_ack.size()), 64'(1));
            if (q_ack.size() > 0)
                chk("tbl ack byte", 64'(q_ack[0]), 64'(tbl[i].ack));
            chk("tbl err_count", 64'(bus.err_count), 64'(tbl[i].err));
            chk("tbl busy", 64'(bus.busy), 64'(0));
            chk("tbl no writes", 64'(q_insn.size() + q_data.size()), 64'(0));
            q_ack.delete();
        end
        exp_err = 16'd3;
        exp_run = 1'b0;

        // instruction frame from the test plan
        pl = '{32'h44332211, 32'hDDCCBBAA};
        send_frame(CMD_WRITE_INSN, 32'h10, 1);
        repeat (2) @(negedge clk);
        chk("ack with final we", 64'(ack_we_same), 64'(1));
        check_q("insn frame");

        // data frame wrapping the address
        pl = '{32'h01234567, 32'h89ABCDEF};
        send_frame(CMD_WRITE_DATA, 32'hFFFFFFFC, 1);
        check_q("wrap frame");

        // run, write, run
        send_byte(CMD_RUN, 1);
        chk("run set", 64'(bus.run), 64'(1));
        e_ack.push_back(8'hA5);
        pl = '{32'h0BADF00D};
        send_frame(CMD_WRITE_INSN, 32'h40, 1);
        chk("run low after frame", 64'(bus.run), 64'(0));
        send_byte(CMD_RUN, 1);
        e_ack.push_back(8'hA5);
        exp_run = 1'b1;
        check_q("run sequence");

        // LEN=0 frame
        pl = {};
        send_frame(CMD_WRITE_DATA, 32'h80, 0);
        check_q("len zero");

        // timeout after a partial word
        send_byte(CMD_WRITE_INSN, 1);
        send_word(32'h100, 1);
        send_word(32'd1, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 0);
        repeat (90) @(negedge clk);
        chk("busy before timeout", 64'(bus.busy), 64'(1));
        chk("no nak before timeout", 64'(q_ack.size()), 64'(0));
        repeat (20) @(negedge clk);
        chk("busy after timeout", 64'(bus.busy), 64'(0));
        e_ack.push_back(8'h5A);
        exp_err++;
        exp_run = 1'b0;
        check_q("timeout");
        pl = '{32'h55667788};
        send_frame(CMD_WRITE_INSN, 32'h104, 1);
        check_q("after timeout");

        // rx_rd held high: one byte only, in IDLE and mid-frame
        @(negedge clk);
        bus.rx_rd = 1'b1;
        bus.rx_data = 8'h7E;
        repeat (10) @(negedge clk);
        bus.rx_rd = 1'b0;
        e_ack.push_back(8'h5A);
        exp_err++;
        check_q("held idle");
        send_byte(CMD_WRITE_DATA, 1);
        @(negedge clk);
        bus.rx_rd = 1'b1;
        bus.rx_data = 8'h00;
        repeat (10) @(negedge clk);
        bus.rx_rd = 1'b0;
        send_byte(8'h02, 1); send_byte(8'h00, 1); send_byte(8'h00, 1);
        send_word(32'd1, 1);
        send_word(32'hCAFEF00D, 1);
        e_data.push_back({32'h200, 32'hCAFEF00D});
        e_ack.push_back(8'hA5);
        check_q("held frame");

        // reset after six payload bytes
        send_byte(CMD_WRITE_INSN, 1);
        send_word(32'h300, 1);
        send_word(32'd2, 1);
        send_word(32'h04030201, 1);
        send_byte(8'h05, 1);
        send_byte(8'h06, 1);
        e_insn.push_back({32'h300, 32'h04030201});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("mid reset");
        reset = 1'b0;
        exp_err = '0;
        exp_run = 1'b0;
        check_q("mid reset");
        pl = '{32'hA1B2C3D4, 32'h00000000};
        send_frame(CMD_WRITE_INSN, 32'h300, 1);
        check_q("after reset");

        // back-to-back byte events
        pl = '{32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF};
        send_frame(CMD_WRITE_DATA, 32'h1000, 0);
        check_q("fast bytes");

        // random traffic
        for (int k = 0; k < 25; k++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                c = 8'($urandom_range(5, 255));
                send_byte(c, $urandom_range(0, 3));
                e_ack.push_back(8'h5A);
                exp_err++;
            end else if (r == 2) begin
                send_byte(CMD_RUN, $urandom_range(0, 3));
                e_ack.push_back(8'hA5);
                exp_run = 1'b1;
            end else if (r == 3) begin
                send_byte(CMD_HALT, $urandom_range(0, 3));
                e_ack.push_back(8'hA5);
                exp_run = 1'b0;
            end else begin
                pl = {};
                for (int j = 0; j < $urandom_range(0, 4); j++)
                    pl.push_back($urandom);
                c = ($urandom_range(0, 1) == 1) ? CMD_WRITE_DATA : CMD_WRITE_INSN;
                send_frame(c, $urandom, $urandom_range(0, 3));
            end
            check_q("random");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
